// File: rtl/ulpi_tx_bridge_pkg.sv
// Shared ULPI transmit constants, FSM state type and PID helper functions
// for the link-side transmit bridge.
package ulpi_tx_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TXCMD,
      ST_WAIT_DIR,
      ST_DATA,
      ST_STOP,
      ST_DRAIN
   } state_t;

   // USB PID nibbles as they appear in tdata[3:0] of the first packet byte.
   typedef enum logic [3:0] {
      PID_OUT   = 4'h1,
      PID_ACK   = 4'h2,
      PID_DATA0 = 4'h3,
      PID_SOF   = 4'h5,
      PID_IN    = 4'h9,
      PID_NAK   = 4'hA,
      PID_DATA1 = 4'hB,
      PID_SETUP = 4'hD,
      PID_STALL = 4'hE
   } pid_t;

   localparam logic [1:0] TXCMD_PREFIX    = 2'b01;
   localparam logic [1:0] TXCMD_PID_CODE  = 2'b00;
   localparam logic [7:0] TXCMD_NOPID     = {TXCMD_PREFIX, 6'b00_0000};
   localparam logic [7:0] STP_END_BYTE    = 8'h00;
   localparam logic [7:0] STP_ABORT_BYTE  = 8'hFF;
   localparam logic [7:0] BUS_IDLE_BYTE   = 8'h00;

   // A PID byte carries its own check nibble: upper half is the complement
   // of the lower half.
   function automatic logic pid_valid(input logic [7:0] pid_byte);
      return pid_byte[7:4] == ~pid_byte[3:0];
   endfunction

   function automatic logic [7:0] txcmd_for(input logic [7:0] pid_byte);
      return {TXCMD_PREFIX, TXCMD_PID_CODE, pid_byte[3:0]};
   endfunction

endpackage

// File: rtl/ulpi_tx_bridge_if.sv
// Encoder byte stream plus ULPI link-side transmit signals of the bridge.
interface ulpi_tx_bridge_if;

   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic [7:0] tdata;
   logic       dir;
   logic       nxt;
   logic       stp;
   logic [7:0] data;
   logic       oe;
   logic       busy;
   logic       error;

   modport slave (
      input  tvalid, tlast, tdata, dir, nxt,
      output tready, stp, data, oe, busy, error
   );

   modport master (
      output tvalid, tlast, tdata, dir, nxt,
      input  tready, stp, data, oe, busy, error
   );

endinterface

// File: rtl/ulpi_tx_bridge.sv
// ULPI transmit bridge: turns an encoder byte stream into TXCMD + data + STP
// on the ULPI link, with DIR turnaround, PHY abort and underrun handling.
module ulpi_tx_bridge #(
   parameter bit CHECK_PID  = 1'b1,
   parameter int TURNAROUND = 1
) (
   input  logic            clock,
   input  logic            reset,
   ulpi_tx_bridge_if.slave bus
);

   import ulpi_tx_bridge_pkg::*;

   localparam int               TA_W    = (TURNAROUND < 1) ? 1 : $clog2(TURNAROUND + 1);
   localparam logic [TA_W-1:0]  TA_LOAD = TA_W'(TURNAROUND);
   localparam logic [TA_W-1:0]  TA_ONE  = TA_W'(1);

   state_t          state, state_n;
   logic [7:0]      data_q, data_n;
   logic [7:0]      hold_q, hold_n;
   logic            oe_q, oe_n;
   logic            stp_q, stp_n;
   logic            err_q, err_n;
   logic            last_q, last_n;
   logic            drain_q, drain_n;
   logic [TA_W-1:0] ta_cnt;
   logic            ta_done;
   logic            pid_ok;
   logic            tready;

   assign ta_done = (ta_cnt == '0);
   assign pid_ok  = !CHECK_PID || pid_valid(bus.tdata);

   // Turnaround counter: reloaded every cycle the PHY owns the bus.
   always_ff @(posedge clock) begin
      if (reset) begin
         ta_cnt <= TA_LOAD;
      end else if (bus.dir) begin
         ta_cnt <= TA_LOAD;
      end else if (!ta_done) begin
         ta_cnt <= ta_cnt - TA_ONE;
      end
   end

   always_comb begin
      tready = 1'b0;
      unique case (state)
         ST_IDLE:           tready = bus.tvalid && !bus.dir && ta_done;
         ST_TXCMD, ST_DATA: tready = bus.nxt && !bus.dir && !last_q;
         ST_DRAIN:          tready = 1'b1;
         default:           tready = 1'b0;
      endcase
   end

   always_comb begin
      state_n = state;
      data_n  = data_q;
      hold_n  = hold_q;
      oe_n    = oe_q;
      stp_n   = stp_q;
      err_n   = 1'b0;
      last_n  = last_q;
      drain_n = drain_q;

      unique case (state)
         ST_IDLE: begin
            if (tready) begin
               if (pid_ok) begin
                  data_n  = txcmd_for(bus.tdata);
                  hold_n  = txcmd_for(bus.tdata);
                  oe_n    = 1'b1;
                  last_n  = bus.tlast;
                  state_n = ST_TXCMD;
               end else begin
                  err_n   = 1'b1;
                  state_n = bus.tlast ? ST_IDLE : ST_DRAIN;
               end
            end
         end

         ST_TXCMD, ST_DATA: begin
            // DIR beats NXT: the byte on the bus is not considered taken.
            if (bus.dir) begin
               oe_n   = 1'b0;
               data_n = BUS_IDLE_BYTE;
               if (state == ST_TXCMD) begin
                  state_n = ST_WAIT_DIR;
               end else begin
                  err_n   = 1'b1;
                  state_n = last_q ? ST_IDLE : ST_DRAIN;
               end
            end else if (bus.nxt) begin
               if (last_q) begin
                  data_n  = STP_END_BYTE;
                  stp_n   = 1'b1;
                  state_n = ST_STOP;
               end else if (bus.tvalid) begin
                  data_n  = bus.tdata;
                  last_n  = bus.tlast;
                  state_n = ST_DATA;
               end else begin
                  // Underrun: STP with all-ones forces a bit-stuff error on the wire.
                  data_n  = STP_ABORT_BYTE;
                  stp_n   = 1'b1;
                  err_n   = 1'b1;
                  drain_n = 1'b1;
                  state_n = ST_STOP;
               end
            end
         end

         ST_WAIT_DIR: begin
            if (!bus.dir && ta_done) begin
               data_n  = hold_q;
               oe_n    = 1'b1;
               state_n = ST_TXCMD;
            end
         end

         ST_STOP: begin
            stp_n   = 1'b0;
            oe_n    = 1'b0;
            data_n  = BUS_IDLE_BYTE;
            drain_n = 1'b0;
            state_n = drain_q ? ST_DRAIN : ST_IDLE;
         end

         ST_DRAIN: begin
            if (bus.tvalid && bus.tlast) begin
               state_n = ST_IDLE;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Link output and control registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         data_q  <= BUS_IDLE_BYTE;
         oe_q    <= 1'b0;
         stp_q   <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         state   <= state_n;
         data_q  <= data_n;
         oe_q    <= oe_n;
         stp_q   <= stp_n;
         err_q   <= err_n;
         last_q  <= last_n;
         drain_q <= drain_n;
      end
   end

   always_ff @(posedge clock) begin
      hold_q <= hold_n;
   end

   assign bus.tready = tready;
   assign bus.data   = data_q;
   assign bus.oe     = oe_q;
   assign bus.stp    = stp_q;
   assign bus.error  = err_q;
   assign bus.busy   = (state != ST_IDLE);

endmodule
